// File: rtl/seven_segment_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds the displayed hex word.
// Optional frame counter output o_Frame_Count is enabled by defining SEVEN_SEG_DEC_FRAME_CNT_EN.
module seven_segment_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_Segment_A,
    input  logic                    i_Segment_B,
    input  logic                    i_Segment_C,
    input  logic                    i_Segment_D,
    input  logic                    i_Segment_E,
    input  logic                    i_Segment_F,
    input  logic                    i_Segment_G,
    input  logic [NUM_DIGITS-1:0]   i_Digit_En,
    input  logic                    i_Clear,
    output logic [4*NUM_DIGITS-1:0] o_Number,
    output logic                    o_Valid,
    output logic [NUM_DIGITS-1:0]   o_Digit_Mask,
    output logic                    o_Error
`ifdef SEVEN_SEG_DEC_FRAME_CNT_EN
    ,
    output logic [15:0]             o_Frame_Count
`endif
);

    localparam logic [NUM_DIGITS-1:0] DIG_ONE   = NUM_DIGITS'(1);
    localparam logic [7:0]            CNT_LAST  = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]            CNT_FULL  = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    // Input sampling and one-sample history
    logic [6:0]              r_pat;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [6:0]              r_prev_pat;
    logic [NUM_DIGITS-1:0]   r_prev_en;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_next;

    logic [NUM_DIGITS-1:0]   r_mask;
    logic [NUM_DIGITS-1:0]   w_mask_next;
    logic [4*NUM_DIGITS-1:0] r_number;
    logic                    r_valid;
    logic                    r_error;

    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_one_hot;
    logic                    w_same;
    logic [3:0]              w_nibble;
    logic                    w_pat_valid;
    logic                    w_pat_blank;
    logic                    w_capture;
    logic                    w_capture_valid;
    logic                    w_capture_invalid;
    logic                    w_frame_done;
    logic                    w_publish;
    logic [4*NUM_DIGITS-1:0] w_shadow_flat;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_pat      <= '0;
            r_en       <= '0;
            r_prev_pat <= '0;
            r_prev_en  <= '0;
        end else begin
            r_pat      <= ~{i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                            i_Segment_E, i_Segment_F, i_Segment_G};
            r_en       <= i_Digit_En;
            r_prev_pat <= r_pat;
            r_prev_en  <= r_en;
        end
    end

    // A low enable selects a digit; w_sel is one-hot exactly in a valid scan slot
    assign w_sel     = ~r_en;
    assign w_one_hot = (w_sel != '0) && ((w_sel & (w_sel - DIG_ONE)) == '0);
    assign w_same    = (r_pat == r_prev_pat) && (r_en == r_prev_en);

    always_comb begin
        w_nibble    = 4'h0;
        w_pat_valid = 1'b1;
        case (r_pat)
            7'h7E:   w_nibble = 4'h0;
            7'h30:   w_nibble = 4'h1;
            7'h6D:   w_nibble = 4'h2;
            7'h79:   w_nibble = 4'h3;
            7'h33:   w_nibble = 4'h4;
            7'h5B:   w_nibble = 4'h5;
            7'h5F:   w_nibble = 4'h6;
            7'h70:   w_nibble = 4'h7;
            7'h7F:   w_nibble = 4'h8;
            7'h7B:   w_nibble = 4'h9;
            7'h77:   w_nibble = 4'hA;
            7'h1F:   w_nibble = 4'hB;
            7'h4E:   w_nibble = 4'hC;
            7'h3D:   w_nibble = 4'hD;
            7'h4F:   w_nibble = 4'hE;
            7'h47:   w_nibble = 4'hF;
            default: w_pat_valid = 1'b0;
        endcase
    end

    assign w_pat_blank = (r_pat == 7'h00);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (i_Clear) begin
            w_state_next = S_WAIT;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_one_hot) begin
                        w_state_next = S_COUNT;
                        w_cnt_next   = 8'd1;
                    end
                end
                S_COUNT: begin
                    if (!w_one_hot) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = '0;
                    end else if (!w_same) begin
                        w_cnt_next   = 8'd1;
                    end else if (r_cnt >= CNT_LAST) begin
                        // Counter saturates here; the held state blocks a second capture
                        w_state_next = S_HELD;
                        w_cnt_next   = CNT_FULL;
                    end else begin
                        w_cnt_next   = r_cnt + 8'd1;
                    end
                end
                S_HELD: begin
                    if (!w_one_hot) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = '0;
                    end else if (!w_same) begin
                        w_state_next = S_COUNT;
                        w_cnt_next   = 8'd1;
                    end
                end
                default: begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_capture = 1'b0;
        case (r_state)
            S_COUNT: w_capture = w_one_hot && w_same && (r_cnt >= CNT_LAST);
            default: w_capture = 1'b0;
        endcase
    end

    assign w_capture_valid   = w_capture && w_pat_valid;
    assign w_capture_invalid = w_capture && !w_pat_valid && !w_pat_blank;
    assign w_frame_done      = (r_mask == '1);
    assign w_publish         = w_frame_done && !i_Clear;
    assign w_mask_next       = (w_frame_done ? '0 : r_mask) |
                               (w_capture_valid ? w_sel : '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] r_nib;
            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    r_nib <= 4'h0;
                end else if (!i_Clear && w_capture_valid && w_sel[gi]) begin
                    r_nib <= w_nibble;
                end
            end
            assign w_shadow_flat[4*gi +: 4] = r_nib;
        end
    endgenerate

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_mask   <= '0;
            r_number <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_number <= w_shadow_flat;
            end
            if (i_Clear) begin
                r_mask  <= '0;
                r_error <= 1'b0;
            end else begin
                r_mask <= w_mask_next;
                if (w_capture_invalid) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

`ifdef SEVEN_SEG_DEC_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_frame_count <= '0;
        end else if (w_publish) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign o_Frame_Count = r_frame_count;
`endif

    assign o_Number     = r_number;
    assign o_Valid      = r_valid;
    assign o_Digit_Mask = r_mask;
    assign o_Error      = r_error;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: decode table vectors plus multi-cycle corner sequences.
// Frame counter checks are included when SEVEN_SEG_DEC_FRAME_CNT_EN is defined.
module tb_seven_segment_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sa, sb, sc, sd, se, sf, sg;
    logic [7:0]  en;
    logic        clr;
    logic [31:0] number;
    logic        valid;
    logic [7:0]  mask;
    logic        err;
`ifdef SEVEN_SEG_DEC_FRAME_CNT_EN
    logic [15:0] fcnt;
    logic [15:0] fc0;
`endif

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;
    int v0;
    logic [31:0] exp_num;

    typedef struct {
        logic [6:0] pat;
        logic       is_valid;
        logic [3:0] nib;
        logic       is_err;
    } vec_t;
    vec_t vecs[20];

    always #5 clk = ~clk;

    seven_segment_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Segment_A  (sa),
        .i_Segment_B  (sb),
        .i_Segment_C  (sc),
        .i_Segment_D  (sd),
        .i_Segment_E  (se),
        .i_Segment_F  (sf),
        .i_Segment_G  (sg),
        .i_Digit_En   (en),
        .i_Clear      (clr),
        .o_Number     (number),
        .o_Valid      (valid),
        .o_Digit_Mask (mask),
        .o_Error      (err)
`ifdef SEVEN_SEG_DEC_FRAME_CNT_EN
        ,
        .o_Frame_Count(fcnt)
`endif
    );

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end, got running expected finished");
        $fatal(1);
    end

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h7E;  4'h1: p = 7'h30;  4'h2: p = 7'h6D;  4'h3: p = 7'h79;
            4'h4: p = 7'h33;  4'h5: p = 7'h5B;  4'h6: p = 7'h5F;  4'h7: p = 7'h70;
            4'h8: p = 7'h7F;  4'h9: p = 7'h7B;  4'hA: p = 7'h77;  4'hB: p = 7'h1F;
            4'hC: p = 7'h4E;  4'hD: p = 7'h3D;  4'hE: p = 7'h4F;  default: p = 7'h47;
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_pat(input logic [6:0] p);
        {sa, sb, sc, sd, se, sf, sg} = ~p;
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        set_pat(p);
        en = ~(8'd1 << d);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        en = 8'hFF;
        set_pat(7'h00);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        en  = 8'hFF;
        @(negedge clk);
        clr = 1'b0;
        idle(2);
    endtask

    task automatic scan(input logic [31:0] w, input int first, input int last);
        for (int d = first; d <= last; d++) show(d, enc(w[4*d +: 4]), 6);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].nib      = 4'(i);
            vecs[i].pat      = enc(4'(i));
            vecs[i].is_valid = 1'b1;
            vecs[i].is_err   = 1'b0;
        end
        vecs[16] = '{pat: 7'h00, is_valid: 1'b0, nib: 4'h0, is_err: 1'b0};
        vecs[17] = '{pat: 7'h01, is_valid: 1'b0, nib: 4'h0, is_err: 1'b1};
        vecs[18] = '{pat: 7'h7C, is_valid: 1'b0, nib: 4'h0, is_err: 1'b1};
        vecs[19] = '{pat: 7'h3E, is_valid: 1'b0, nib: 4'h0, is_err: 1'b1};

        rst_n = 1'b0;
        clr   = 1'b0;
        en    = 8'hFF;
        set_pat(7'h00);
        repeat (3) @(negedge clk);
        check("reset_number", number, 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_mask", 32'(mask), 32'h0);
        check("reset_error", 32'(err), 32'h0);
        rst_n = 1'b1;
        idle(2);

        v0 = valid_cnt;
        scan(32'h1234ABCD, 0, 7);
        idle(2);
        $display("scan 1234ABCD: number=%h valid_pulses=%0d", number, valid_cnt - v0);
        check("scan_number", number, 32'h1234ABCD);
        check("scan_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("scan_error", 32'(err), 32'h0);
        check("scan_mask", 32'(mask), 32'h0);

        // Capture lands exactly STABLE_CYCLES edges after the pattern is sampled
        pulse_clear();
        set_pat(enc(4'h5));
        en = 8'hFE;
        repeat (4) @(negedge clk);
        check("latency_before", 32'(mask), 32'h0);
        @(negedge clk);
        check("latency_at", 32'(mask), 32'h1);
        $display("latency: mask=%h", mask);

        pulse_clear();
        v0 = valid_cnt;
        show(0, 7'h30, 3);
        show(0, 7'h6D, 4);
        idle(1);
        check("glitch_mask", 32'(mask), 32'h1);
        scan(32'h98765432, 1, 7);
        idle(2);
        $display("glitch: number=%h", number);
        check("glitch_number", number, 32'h98765432);
        check("glitch_valid_pulses", 32'(valid_cnt - v0), 32'd1);

        pulse_clear();
        show(0, enc(4'h7), 6);
        show(3, 7'h01, 5);
        $display("invalid: error=%b mask=%h", err, mask);
        check("invalid_error", 32'(err), 32'h1);
        check("invalid_mask", 32'(mask), 32'h1);
        pulse_clear();
        check("clear_error", 32'(err), 32'h0);
        check("clear_mask", 32'(mask), 32'h0);

        show(0, enc(4'h4), 6);
        check("twohot_pre_mask", 32'(mask), 32'h1);
        v0 = valid_cnt;
        set_pat(enc(4'h9));
        en = 8'hFC;
        repeat (10) @(negedge clk);
        $display("two-hot: mask=%h error=%b", mask, err);
        check("twohot_mask", 32'(mask), 32'h1);
        check("twohot_error", 32'(err), 32'h0);
        check("twohot_valid_pulses", 32'(valid_cnt - v0), 32'd0);

        // Clear on the completion edge suppresses the publish
        pulse_clear();
        v0 = valid_cnt;
        scan(32'hCAFEF00D, 0, 6);
        show(7, enc(4'hC), 5);
        check("clrdone_mask_full", 32'(mask), 32'hFF);
        clr = 1'b1;
        en  = 8'hFF;
        set_pat(7'h00);
        @(negedge clk);
        clr = 1'b0;
        idle(2);
        $display("clear-at-completion: number=%h valid_pulses=%0d", number, valid_cnt - v0);
        check("clrdone_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        check("clrdone_number", number, 32'h98765432);
        check("clrdone_mask", 32'(mask), 32'h0);

        exp_num = 32'h98765432;
        for (int i = 0; i < 20; i++) begin
            pulse_clear();
            v0 = valid_cnt;
            for (int d = 0; d < 8; d++) show(d, vecs[i].pat, 6);
            idle(2);
            if (vecs[i].is_valid) exp_num = {8{vecs[i].nib}};
            $display("vec %0d pat=%h number=%h error=%b pulses=%0d", i, vecs[i].pat, number, err,
                     valid_cnt - v0);
            check("vec_number", number, exp_num);
            check("vec_valid_pulses", 32'(valid_cnt - v0), vecs[i].is_valid ? 32'd1 : 32'd0);
            check("vec_error", 32'(err), 32'(vecs[i].is_err));
            check("vec_mask", 32'(mask), 32'h0);
        end

        // Error left set by the last vector must also drop on reset
        idle(2);
        scan(32'h11223344, 0, 4);
        check("midframe_mask", 32'(mask), 32'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: number=%h mask=%h error=%b", number, mask, err);
        check("areset_number", number, 32'h0);
        check("areset_valid", 32'(valid), 32'h0);
        check("areset_mask", 32'(mask), 32'h0);
        check("areset_error", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        v0 = valid_cnt;
        scan(32'hDEADBEEF, 0, 7);
        idle(2);
        $display("scan DEADBEEF: number=%h", number);
        check("deadbeef_number", number, 32'hDEADBEEF);
        check("deadbeef_valid_pulses", 32'(valid_cnt - v0), 32'd1);

`ifdef SEVEN_SEG_DEC_FRAME_CNT_EN
        fc0 = fcnt;
        check("fcnt_after_reset_frame", 32'(fc0), 32'd1);
        scan(32'h01234567, 0, 7);
        scan(32'h89ABCDEF, 0, 7);
        scan(32'h00FF00FF, 0, 7);
        idle(2);
        pulse_clear();
        $display("frame count: %0d", fcnt);
        check("fcnt_three_frames", 32'(fcnt), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
- Debug snoop block that observes a multiplexed, active-low 7-segment bus (segment lines plus per-digit enables) and recovers the hex value being displayed.
- Each stable digit pattern is decoded back to a nibble, and the nibbles are assembled into a NUM_DIGITS*4-bit word.
- A word is published once every digit has been captured.
- Sits beside the display driver in the debug path, so the on-board display output can be checked in simulation and with FPGA logic capture.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..8); digit i owns bits [4i+3:4i] of o_Number.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (2..255).

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Rst_n  input  1  reset, asynchronous assert, active-low.
- i_Segment_A..i_Segment_G  input  1 each  segment lines, active-low (0 = lit).
- i_Digit_En  input  NUM_DIGITS  digit enables, active-low; exactly one bit low means a valid scan slot.
- i_Clear  input  1  synchronous clear of o_Error and of the partial frame.
- o_Number  output  4*NUM_DIGITS  last completed decoded word.
- o_Valid  output  1  one-cycle pulse when o_Number updates.
- o_Digit_Mask  output  NUM_DIGITS  digits captured in the current partial frame.
- o_Error  output  1  sticky flag: a stable, non-blank, unrecognised pattern was seen.

Behaviour:
- Reset (i_Rst_n low, asynchronous): all outputs and internal registers are 0; the FSM goes to S_WAIT.
- Input stage: segments and enables are registered every cycle.
  - pat[6:0] = ~{A,B,C,D,E,F,G}, with A as bit 6.
  - en_q = the registered i_Digit_En.
- Decode table (pat -> nibble): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F.
  - pat 00 is blank.
  - Any other pattern is invalid.
- one_hot: exactly one bit of en_q is 0. Its index is the digit number d.
- FSM:
  - S_WAIT: if one_hot, load cnt=1 and go to S_COUNT.
  - S_COUNT:
    - If one_hot and (pat, en_q) equal the previous sample, cnt++.
    - If one_hot but the sample changed, cnt=1 and stay in S_COUNT.
    - If not one_hot, go to S_WAIT.
    - When cnt reaches STABLE_CYCLES, capture once and go to S_HELD.
  - S_HELD: stay until (pat, en_q) changes or one_hot drops, then re-enter S_COUNT with cnt=1 or go to S_WAIT. A held pattern is never captured twice.
- Capture action:
  - Valid pattern: shadow[d] <= nibble and mask[d] <= 1. A repeat capture of the same digit overwrites its nibble.
  - Blank: nothing happens.
  - Invalid: o_Error <= 1; shadow and mask are unchanged.
- Frame complete: on the cycle after the mask becomes all-ones:
  - o_Number <= shadow.
  - o_Valid = 1 for exactly one cycle.
  - mask <= 0.
- Latency: a pattern applied at edge k is captured at edge k+STABLE_CYCLES. If that capture completes the frame, o_Valid is high after edge k+STABLE_CYCLES+1.
- i_Clear:
  - Clears o_Error and the mask and returns the FSM to S_WAIT. o_Number is held.
  - Clear wins over a simultaneous capture or error.
  - If clear coincides with frame completion, o_Valid is suppressed.
- Reset mid-frame discards the partial frame; o_Number returns to 0.
- o_Digit_Mask mirrors the internal mask.
- The counter saturates at STABLE_CYCLES, so there is no wrap-around.

Optional Feature:
- Macro: SEVEN_SEG_DEC_FRAME_CNT_EN.
- Defined: adds output o_Frame_Count [15:0].
  - Reset value 0.
  - Increments on each o_Valid pulse and wraps from FFFF to 0000.
  - i_Clear does not affect it.
- Undefined: the port and counter are absent.

Test Plan:
- Scan 0x1234ABCD, each digit held 6 cycles, STABLE_CYCLES=4 -> one o_Valid pulse; o_Number=0x1234ABCD; o_Error=0.
- Digit 0 shows pattern 0x30 for only 3 cycles, then 0x6D for 4 cycles -> nibble 2 captured; 1 is never captured.
- Digit 3 shows invalid pattern 0x01 for 5 cycles -> o_Error=1, mask bit 3 stays 0; i_Clear then -> o_Error=0 and mask=0.
- i_Digit_En=0xFC (two digits active) for 10 cycles -> no capture, FSM stays in S_WAIT, mask unchanged.
- i_Rst_n pulsed low asynchronously mid-frame after 5 captures -> all outputs 0 immediately; a new full scan of 0xDEADBEEF -> o_Number=0xDEADBEEF.
- With SEVEN_SEG_DEC_FRAME_CNT_EN, 3 full frames -> o_Frame_Count=3; force 0xFFFF then 1 frame -> 0x0000.
